// File: rtl/label_ram_sched.sv
// Label-RAM access controller: muxes wavefront/backtrace writes onto one RAM port,
// with a self-timed clear sequencer and saturating label increment.
module label_ram_sched #(
  parameter int unsigned         ADDR_LEN  = 16,
  parameter int unsigned         DATA_LEN  = 8,
  parameter int unsigned         CLR_DEPTH = 2**ADDR_LEN,
  parameter logic [DATA_LEN-1:0] CLR_VALUE = '0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                clr_start,
  input  logic                BC_mode,
  input  logic                wen_cgr,
  input  logic                wen_sqg,
  input  logic [ADDR_LEN-1:0] BC_rd_addr,
  input  logic [ADDR_LEN-1:0] BC_wr_addr,
  input  logic [ADDR_LEN-1:0] XY,
  input  logic [DATA_LEN-1:0] MLXY,
  input  logic [DATA_LEN-1:0] ML1XY,
  input  logic                ovf_clr,
  output logic                wr_en,
  output logic [ADDR_LEN-1:0] wr_addr,
  output logic [DATA_LEN-1:0] wr_data,
  output logic [ADDR_LEN-1:0] rd_addr,
  output logic                req_ready,
  output logic                clr_busy,
  output logic                clr_done,
  output logic                lbl_ovf
);

  // One extra counter bit so a full-depth clear can reach CLR_DEPTH without wrapping.
  localparam int unsigned      CNT_W   = ADDR_LEN + 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CLR_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   clr_cnt;

  logic                req_c;
  logic                take_c;
  logic                lbl_max_c;
  logic [DATA_LEN-1:0] lbl_inc_c;

  // Request acceptance and saturating increment of the current label.
  always_comb begin
    req_c     = wen_cgr | wen_sqg;
    take_c    = (state == S_IDLE) & req_ready & req_c & ~clr_start;
    lbl_max_c = &MLXY;
    lbl_inc_c = lbl_max_c ? MLXY : MLXY + DATA_LEN'(1);
  end

  // The state tracks what the registered outputs currently show.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      clr_cnt   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_addr   <= '0;
      req_ready <= 1'b0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
      lbl_ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          rd_addr <= BC_mode ? XY : BC_rd_addr;
          if (clr_start) begin
            state     <= S_CLEAR;
            clr_cnt   <= CNT_W'(1);
            wr_en     <= 1'b1;
            wr_addr   <= '0;
            wr_data   <= CLR_VALUE;
            clr_busy  <= 1'b1;
            req_ready <= 1'b0;
          end else begin
            req_ready <= 1'b1;
            wr_en     <= take_c;
            if (take_c) begin
              wr_addr <= BC_mode ? XY : BC_wr_addr;
              wr_data <= BC_mode ? lbl_inc_c : ML1XY;
            end
          end
        end
        S_CLEAR: begin
          if (clr_cnt == CNT_END) begin
            state    <= S_DONE;
            wr_en    <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            wr_addr <= clr_cnt[ADDR_LEN-1:0];
            clr_cnt <= clr_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          clr_cnt   <= '0;
          clr_done  <= 1'b0;
          clr_busy  <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase

      if (take_c && BC_mode && lbl_max_c)
        lbl_ovf <= 1'b1;
      else if (ovf_clr)
        lbl_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_label_ram_sched.sv
// Randomised self-checking bench for label_ram_sched against a cycle-level behavioural model.
module tb_label_ram_sched;

  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        clr_start = 1'b0, BC_mode = 1'b0, wen_cgr = 1'b0, wen_sqg = 1'b0, ovf_clr = 1'b0;
  logic [15:0] BC_rd_addr = '0, BC_wr_addr = '0, XY = '0;
  logic [7:0]  MLXY = '0, ML1XY = '0;

  logic        wr_en, req_ready, clr_busy, clr_done, lbl_ovf;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_data;

  logic        s_wr_en, s_req_ready, s_clr_busy, s_clr_done, s_lbl_ovf;
  logic [2:0]  s_wr_addr, s_rd_addr;
  logic [7:0]  s_wr_data;

  always #5 CLK = ~CLK;

  label_ram_sched #(.ADDR_LEN(16), .DATA_LEN(8), .CLR_DEPTH(DEPTH), .CLR_VALUE(8'h00)) dut (
    .CLK(CLK), .RST_N(RST_N), .clr_start(clr_start), .BC_mode(BC_mode),
    .wen_cgr(wen_cgr), .wen_sqg(wen_sqg), .BC_rd_addr(BC_rd_addr), .BC_wr_addr(BC_wr_addr),
    .XY(XY), .MLXY(MLXY), .ML1XY(ML1XY), .ovf_clr(ovf_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .req_ready(req_ready), .clr_busy(clr_busy), .clr_done(clr_done), .lbl_ovf(lbl_ovf));

  // Narrow instance with default depth: clears the whole 3-bit space 0..7.
  label_ram_sched #(.ADDR_LEN(3), .DATA_LEN(8)) dut_s (
    .CLK(CLK), .RST_N(RST_N), .clr_start(clr_start), .BC_mode(BC_mode),
    .wen_cgr(wen_cgr), .wen_sqg(wen_sqg), .BC_rd_addr(BC_rd_addr[2:0]), .BC_wr_addr(BC_wr_addr[2:0]),
    .XY(XY[2:0]), .MLXY(MLXY), .ML1XY(ML1XY), .ovf_clr(ovf_clr),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .rd_addr(s_rd_addr),
    .req_ready(s_req_ready), .clr_busy(s_clr_busy), .clr_done(s_clr_done), .lbl_ovf(s_lbl_ovf));

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: m_pos = clear write currently shown (0..DEPTH-1), DEPTH = done cycle, -1 = idle.
  int          m_pos;
  bit          m_took;
  logic        e_wr_en, e_req_ready, e_clr_busy, e_clr_done, e_lbl_ovf;
  logic [15:0] e_wr_addr, e_rd_addr;
  logic [7:0]  e_wr_data;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_pos = -1;
      {e_wr_en, e_req_ready, e_clr_busy, e_clr_done, e_lbl_ovf} = '0;
      e_wr_addr = '0; e_rd_addr = '0; e_wr_data = '0;
    end else begin
      m_took = 1'b0;
      if (m_pos >= 0) begin
        m_pos = m_pos + 1;
        if (m_pos > DEPTH) m_pos = -1;
      end else begin
        e_rd_addr = BC_mode ? XY : BC_rd_addr;
        if (clr_start) m_pos = 0;
        else if (e_req_ready && (wen_cgr || wen_sqg)) begin
          m_took = 1'b1;
          if (BC_mode) begin
            e_wr_addr = XY;
            e_wr_data = (MLXY == 8'hFF) ? 8'hFF : 8'(int'(MLXY) + 1);
          end else begin
            e_wr_addr = BC_wr_addr;
            e_wr_data = ML1XY;
          end
        end
      end
      if (m_took && BC_mode && MLXY == 8'hFF) e_lbl_ovf = 1'b1;
      else if (ovf_clr) e_lbl_ovf = 1'b0;
      if (m_pos >= 0 && m_pos < DEPTH) begin
        e_wr_addr = 16'(m_pos);
        e_wr_data = 8'h00;
      end
      e_wr_en     = (m_pos >= 0 && m_pos < DEPTH) || m_took;
      e_clr_done  = (m_pos == DEPTH);
      e_clr_busy  = (m_pos >= 0);
      e_req_ready = (m_pos < 0);
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("m_wr_en", 64'(wr_en), 64'(e_wr_en));
      chk("m_wr_addr", 64'(wr_addr), 64'(e_wr_addr));
      chk("m_wr_data", 64'(wr_data), 64'(e_wr_data));
      chk("m_rd_addr", 64'(rd_addr), 64'(e_rd_addr));
      chk("m_req_ready", 64'(req_ready), 64'(e_req_ready));
      chk("m_clr_busy", 64'(clr_busy), 64'(e_clr_busy));
      chk("m_clr_done", 64'(clr_done), 64'(e_clr_done));
      chk("m_lbl_ovf", 64'(lbl_ovf), 64'(e_lbl_ovf));
    end
  end

  initial begin
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    cmp_en = 1'b1;
    chk("rst_outputs", 64'({wr_en, wr_addr, wr_data, rd_addr, req_ready, clr_busy, clr_done, lbl_ovf}), 64'd0);
    RST_N = 1'b1;

    // Wavefront write with increment
    @(negedge CLK);
    chk("rel_ready", 64'(req_ready), 64'd1);
    BC_mode = 1'b1; wen_cgr = 1'b1; XY = 16'h0123; MLXY = 8'h05;
    @(negedge CLK);
    chk("bc_wr_en", 64'(wr_en), 64'd1);
    chk("bc_wr_addr", 64'(wr_addr), 64'h0123);
    chk("bc_wr_data", 64'(wr_data), 64'h06);
    chk("bc_rd_addr", 64'(rd_addr), 64'h0123);

    // Saturation sets sticky overflow
    wen_cgr = 1'b0; wen_sqg = 1'b1; MLXY = 8'hFF;
    @(negedge CLK);
    chk("sat_data", 64'(wr_data), 64'hFF);
    chk("sat_ovf", 64'(lbl_ovf), 64'd1);

    // Backtrace write
    wen_sqg = 1'b0; BC_mode = 1'b0; wen_cgr = 1'b1;
    BC_wr_addr = 16'h00AA; ML1XY = 8'h3C; BC_rd_addr = 16'h00AB;
    @(negedge CLK);
    chk("bt_wr_addr", 64'(wr_addr), 64'h00AA);
    chk("bt_wr_data", 64'(wr_data), 64'h3C);
    chk("bt_rd_addr", 64'(rd_addr), 64'h00AB);
    chk("ovf_sticky", 64'(lbl_ovf), 64'd1);

    // Clear with competing requests and a retried clr_start
    clr_start = 1'b1;
    @(negedge CLK);
    clr_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("clr_en", 64'(wr_en), 64'd1);
      chk("clr_addr", 64'(wr_addr), 64'(i));
      chk("clr_data", 64'(wr_data), 64'd0);
      chk("clr_busy", 64'(clr_busy), 64'd1);
      chk("clr_ready", 64'(req_ready), 64'd0);
      chk("s_clr_addr", 64'(s_wr_addr), 64'(i));
      chk("s_clr_en", 64'(s_wr_en), 64'd1);
      clr_start = (i == 3);
      @(negedge CLK);
    end
    clr_start = 1'b0;
    chk("clr_done", 64'(clr_done), 64'd1);
    chk("clr_done_busy", 64'(clr_busy), 64'd1);
    chk("clr_done_en", 64'(wr_en), 64'd0);
    chk("s_clr_done", 64'(s_clr_done), 64'd1);
    @(negedge CLK);
    chk("post_done", 64'(clr_done), 64'd0);
    chk("post_busy", 64'(clr_busy), 64'd0);
    chk("post_ready", 64'(req_ready), 64'd1);
    chk("post_no_wr", 64'(wr_en), 64'd0);
    chk("s_post_done", 64'(s_clr_done), 64'd0);
    chk("ovf_after_clr", 64'(lbl_ovf), 64'd1);
    wen_cgr = 1'b0;

    // Set beats clear, then clear alone
    BC_mode = 1'b1; wen_sqg = 1'b1; MLXY = 8'hFF; ovf_clr = 1'b1;
    @(negedge CLK);
    chk("ovf_set_wins", 64'(lbl_ovf), 64'd1);
    wen_sqg = 1'b0;
    @(negedge CLK);
    chk("ovf_cleared", 64'(lbl_ovf), 64'd0);
    ovf_clr = 1'b0;

    // Asynchronous reset in the middle of a clear
    clr_start = 1'b1;
    @(negedge CLK);
    clr_start = 1'b0;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 chk("async_rst", 64'({wr_en, wr_addr, wr_data, rd_addr, req_ready, clr_busy, clr_done}), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_abort_ready", 64'(req_ready), 64'd1);
    chk("rst_abort_done", 64'(clr_done), 64'd0);

    // Randomised traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      BC_mode    = 1'($urandom);
      wen_cgr    = ($urandom_range(0, 2) == 0);
      wen_sqg    = ($urandom_range(0, 2) == 0);
      XY         = 16'($urandom);
      BC_rd_addr = 16'($urandom);
      BC_wr_addr = 16'($urandom);
      MLXY       = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      ML1XY      = 8'($urandom);
      clr_start  = ($urandom_range(0, 39) == 0);
      ovf_clr    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
      end
      @(negedge CLK);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
